// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline writeback and buffered long-latency returns onto one regfile write port
module regfile_wb_arbiter #(
  parameter int width_p           = 32,
  parameter int els_p             = 32,
  parameter int fifo_els_p        = 4,
  parameter int starve_limit_p    = 8,
  parameter int x0_tied_to_zero_p = 1,
  localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int count_width_lp   = $clog2(fifo_els_p + 1),
  localparam int starve_width_lp  = $clog2(starve_limit_p + 1),
  localparam int ptr_width_lp     = $clog2(fifo_els_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      pipe_v_i,
  input  logic [addr_width_lp-1:0]  pipe_addr_i,
  input  logic [width_p-1:0]        pipe_data_i,
  output logic                      pipe_ready_o,
  input  logic                      rtn_v_i,
  input  logic [addr_width_lp-1:0]  rtn_addr_i,
  input  logic [width_p-1:0]        rtn_data_i,
  output logic                      rtn_ready_o,
  output logic                      w_v_o,
  output logic [addr_width_lp-1:0]  w_addr_o,
  output logic [width_p-1:0]        w_data_o,
  output logic [count_width_lp-1:0] fifo_count_o
);

  localparam bit x0_zero_lp = (x0_tied_to_zero_p != 0);

  logic [width_p-1:0]         data_mem [fifo_els_p];
  logic [addr_width_lp-1:0]   addr_mem [fifo_els_p];
  logic [ptr_width_lp-1:0]    rd_ptr_r, wr_ptr_r;
  logic [count_width_lp-1:0]  count_r;
  logic [starve_width_lp-1:0] starve_r;

  logic empty, full, force_drain, pipe_real, rtn_drop, enq, deq;

  assign empty       = (count_r == '0);
  assign full        = (count_r == count_width_lp'(fifo_els_p));
  assign force_drain = !empty && (full || starve_r == starve_width_lp'(starve_limit_p));
  assign pipe_real   = pipe_v_i && !(x0_zero_lp && pipe_addr_i == '0);
  assign rtn_drop    = x0_zero_lp && rtn_addr_i == '0;

  // Ready depends only on registered fullness so no path runs from the pipeline to the return side.
  assign rtn_ready_o  = !reset_i && !full;
  assign enq          = rtn_v_i && rtn_ready_o && !rtn_drop;
  assign fifo_count_o = count_r;

  // Pick the write-port owner: forced drain, then pipeline, then opportunistic drain.
  always_comb begin
    w_v_o        = 1'b0;
    w_addr_o     = '0;
    w_data_o     = '0;
    pipe_ready_o = 1'b0;
    deq          = 1'b0;
    if (!reset_i) begin
      pipe_ready_o = 1'b1;
      if (force_drain) begin
        w_v_o        = 1'b1;
        w_addr_o     = addr_mem[rd_ptr_r];
        w_data_o     = data_mem[rd_ptr_r];
        deq          = 1'b1;
        pipe_ready_o = !pipe_real;
      end else if (pipe_real) begin
        w_v_o    = 1'b1;
        w_addr_o = pipe_addr_i;
        w_data_o = pipe_data_i;
      end else if (!empty) begin
        w_v_o    = 1'b1;
        w_addr_o = addr_mem[rd_ptr_r];
        w_data_o = data_mem[rd_ptr_r];
        deq      = 1'b1;
      end
    end
  end

  // Return buffer storage; contents need no reset because count gates every read.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      data_mem[wr_ptr_r] <= rtn_data_i;
      addr_mem[wr_ptr_r] <= rtn_addr_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (enq) wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
      if (deq) rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
      if (enq && !deq)      count_r <= count_r + count_width_lp'(1);
      else if (!enq && deq) count_r <= count_r - count_width_lp'(1);
    end
  end

  // Count consecutive cycles a waiting head has lost arbitration, saturating at the limit.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_r <= '0;
    end else if (empty || deq) begin
      starve_r <= '0;
    end else if (starve_r != starve_width_lp'(starve_limit_p)) begin
      starve_r <= starve_r + starve_width_lp'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed-vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_v;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        pipe_ready;
  logic        rtn_v;
  logic [4:0]  rtn_addr;
  logic [31:0] rtn_data;
  logic        rtn_ready;
  logic        w_v;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [2:0]  fifo_count;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .pipe_v_i     (pipe_v),
    .pipe_addr_i  (pipe_addr),
    .pipe_data_i  (pipe_data),
    .pipe_ready_o (pipe_ready),
    .rtn_v_i      (rtn_v),
    .rtn_addr_i   (rtn_addr),
    .rtn_data_i   (rtn_data),
    .rtn_ready_o  (rtn_ready),
    .w_v_o        (w_v),
    .w_addr_o     (w_addr),
    .w_data_o     (w_data),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls, stall_idx, r, exp_next;
    int acc_cyc [5];
    logic ready_s;

    reset = 1'b1;
    pipe_v = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h2;
    rtn_v = 1'b1;  rtn_addr = 5'd3;  rtn_data = 32'h3;

    // reset state
    @(negedge clk);
    check("rst_w_v", w_v, 0);
    check("rst_pipe_ready", pipe_ready, 0);
    check("rst_rtn_ready", rtn_ready, 0);
    check("rst_count", fifo_count, 0);
    #2 reset = 1'b0;
    pipe_v = 1'b0; rtn_v = 1'b0;
    @(negedge clk);
    check("post_rst_rtn_ready", rtn_ready, 1);
    check("post_rst_pipe_ready", pipe_ready, 1);
    check("post_rst_w_v", w_v, 0);
    step();

    // basic arbitration
    pipe_v = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hA5A5A5A5;
    rtn_v = 1'b1;  rtn_addr = 5'd7;  rtn_data = 32'h11;
    @(negedge clk);
    check("basic_w_v", w_v, 1);
    check("basic_w_addr", w_addr, 5);
    check("basic_w_data", w_data, 32'hA5A5A5A5);
    check("basic_pipe_ready", pipe_ready, 1);
    step();
    check("basic_count1", fifo_count, 1);
    pipe_v = 1'b0; rtn_v = 1'b0;
    @(negedge clk);
    check("basic_rtn_w_v", w_v, 1);
    check("basic_rtn_addr", w_addr, 7);
    check("basic_rtn_data", w_data, 32'h11);
    step();
    check("basic_count0", fifo_count, 0);

    // starvation: return to r9 while the pipe writes r1, r2, ...
    pipe_v = 1'b1; pipe_addr = 5'd1; pipe_data = 32'd1;
    rtn_v = 1'b1;  rtn_addr = 5'd9;  rtn_data = 32'h99;
    step();
    rtn_v = 1'b0;
    pipe_addr = 5'd2; pipe_data = 32'd2;
    stalls = 0; stall_idx = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!pipe_ready) begin
        stalls++;
        stall_idx = i;
        check("starve_drain_addr", w_addr, 9);
        check("starve_drain_data", w_data, 32'h99);
      end
      if (i == 9) begin
        check("starve_held_addr", w_addr, 10);
        check("starve_held_data", w_data, 10);
      end
      ready_s = pipe_ready;
      step();
      if (ready_s) begin
        pipe_addr = pipe_addr + 5'd1;
        pipe_data = {27'd0, pipe_addr};
      end
    end
    check("starve_stall_count", stalls, 1);
    check("starve_stall_index", stall_idx, 8);
    check("starve_count_end", fifo_count, 0);

    // full FIFO: busy pipe, five back-to-back returns r11..r15
    pipe_addr = 5'd1; pipe_data = 32'd1;
    for (int k = 0; k < 5; k++) acc_cyc[k] = -1;
    r = 0;
    for (int c = 0; c < 8; c++) begin
      rtn_v    = (r < 5);
      rtn_addr = 5'(11 + r);
      rtn_data = 32'h100 + 32'(11 + r);
      @(negedge clk);
      if (c == 4) begin
        check("full_count", fifo_count, 4);
        check("full_rtn_ready", rtn_ready, 0);
        check("full_force_pipe_ready", pipe_ready, 0);
        check("full_force_addr", w_addr, 11);
        check("full_force_data", w_data, 32'h10B);
      end
      if (rtn_v && rtn_ready) acc_cyc[r] = c;
      ready_s = pipe_ready;
      step();
      if (acc_cyc[r] == c) r++;
      if (ready_s) begin
        pipe_addr = pipe_addr + 5'd1;
        pipe_data = {27'd0, pipe_addr};
      end
    end
    check("full_acc4_cycle", acc_cyc[3], 3);
    check("full_acc5_cycle", acc_cyc[4], 5);
    pipe_v = 1'b0; rtn_v = 1'b0;
    for (int c = 0; c < 10 && fifo_count != 0; c++) step();
    check("full_drained", fifo_count, 0);

    // x0 handling
    rtn_v = 1'b1; rtn_addr = 5'd0; rtn_data = 32'hDEAD;
    @(negedge clk);
    check("x0_rtn_ready", rtn_ready, 1);
    step();
    rtn_v = 1'b0;
    @(negedge clk);
    check("x0_rtn_no_write", w_v, 0);
    check("x0_rtn_count", fifo_count, 0);
    step();
    pipe_v = 1'b1; pipe_addr = 5'd4; pipe_data = 32'h44;
    rtn_v = 1'b1;  rtn_addr = 5'd3;  rtn_data = 32'h33;
    step();
    rtn_v = 1'b0;
    pipe_addr = 5'd0; pipe_data = 32'hBAD;
    @(negedge clk);
    check("x0_pipe_ready", pipe_ready, 1);
    check("x0_pipe_drain_v", w_v, 1);
    check("x0_pipe_drain_addr", w_addr, 3);
    check("x0_pipe_drain_data", w_data, 32'h33);
    step();
    check("x0_pipe_count", fifo_count, 0);
    @(negedge clk);
    check("x0_pipe_empty_w_v", w_v, 0);
    check("x0_pipe_empty_ready", pipe_ready, 1);
    step();
    pipe_v = 1'b0;

    // pointer wrap: 12 returns, idle pipe
    exp_next = 1;
    for (int c = 0; c < 14; c++) begin
      rtn_v    = (c < 12);
      rtn_addr = 5'(c + 1);
      rtn_data = 32'(c + 1);
      @(negedge clk);
      check("wrap_count_le1", 32'(fifo_count <= 3'd1), 1);
      if (w_v) begin
        check("wrap_addr", w_addr, 32'(exp_next));
        check("wrap_data", w_data, 32'(exp_next));
        exp_next++;
      end
      step();
    end
    check("wrap_total", exp_next, 13);

    // reset mid-operation with three buffered returns
    pipe_v = 1'b1; pipe_addr = 5'd1; pipe_data = 32'd1;
    for (int c = 0; c < 3; c++) begin
      rtn_v = 1'b1; rtn_addr = 5'(20 + c); rtn_data = 32'(20 + c);
      step();
      pipe_addr = pipe_addr + 5'd1;
      pipe_data = {27'd0, pipe_addr};
    end
    rtn_v = 1'b0; pipe_v = 1'b0;
    @(negedge clk);
    check("midrst_count_before", fifo_count, 3);
    reset = 1'b1;
    #1;
    check("midrst_w_v", w_v, 0);
    check("midrst_count", fifo_count, 0);
    step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_stale", w_v, 0);
      step();
    end
    check("midrst_count_after", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end for the core register file. It merges two write sources onto the single register-file write port. The in-order pipeline writeback has default priority. Long-latency returns (remote loads, FPU/divider results) are buffered in a small FIFO and drained into free write slots. A starvation bound and a full-FIFO override guarantee that buffered returns always make progress.

## Interface
Parameters:
- width_p, 32, data width of a register
- els_p, 32, number of registers
- fifo_els_p, 4, return-buffer depth (power of two, ≥2)
- starve_limit_p, 8, maximum number of consecutive cycles a non-empty FIFO may lose arbitration
- x0_tied_to_zero_p, 1, when 1, writes to address 0 are discarded
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`, derived

Ports:
- clk_i  in  1  clock; all state on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- pipe_v_i  in  1  pipeline writeback valid
- pipe_addr_i  in  addr_width_lp  pipeline destination register
- pipe_data_i  in  width_p  pipeline write data
- pipe_ready_o  out  1  pipeline write accepted this cycle; when pipe_v_i=1 and pipe_ready_o=0 the pipeline must stall and hold its inputs
- rtn_v_i  in  1  return valid
- rtn_addr_i  in  addr_width_lp  return destination register
- rtn_data_i  in  width_p  return data
- rtn_ready_o  out  1  return accepted when rtn_v_i & rtn_ready_o
- w_v_o  out  1  register-file write enable
- w_addr_o  out  addr_width_lp  register-file write address
- w_data_o  out  width_p  register-file write data
- fifo_count_o  out  clog2(fifo_els_p+1)  number of buffered returns

## Operation
- **FIFO.** Circular buffer with read and write pointers plus a count.
  - Enqueue on rtn_v_i & rtn_ready_o.
  - rtn_ready_o = !full. It never depends on a same-cycle dequeue, so there is no combinational path from the pipeline to the return interface.
- **x0 drop.** With x0_tied_to_zero_p=1, an accepted return to address 0 is consumed without being enqueued.
- **Starvation counter** (saturating, clog2(starve_limit_p+1) bits):
  - clears when the FIFO is empty or a dequeue occurs;
  - otherwise increments each cycle the FIFO is non-empty.
- **force_drain** = FIFO non-empty & (count==fifo_els_p | starve_cnt==starve_limit_p).
- **Pipeline is a real write** when pipe_v_i & !(x0_tied_to_zero_p & pipe_addr_i==0). An x0 pipeline write always gets pipe_ready_o=1 and uses no port slot.
- **Arbitration, per cycle, in priority order:**
  - force_drain: FIFO head writes; pipe_ready_o=0 if the pipeline has a real write, otherwise 1.
  - Real pipeline write: the pipeline writes and pipe_ready_o=1.
  - FIFO non-empty: the head writes (dequeue).
  - Otherwise w_v_o=0.
- pipe_ready_o=1 whenever pipe_v_i=0.
- **Ordering.** There is no address interlock. The issue scoreboard guarantees that the pipeline and returns never target the same register concurrently. Returns are written in arrival order.
- **Outputs.** w_addr_o and w_data_o come from the winning source. They are don't-care when w_v_o=0 but must be driven to a known value; zero is used.

## Timing
- **Reset (asserted asynchronously):**
  - FIFO empty, pointers 0, starvation counter 0, fifo_count_o=0.
  - While reset_i=1: w_v_o=0, pipe_ready_o=0, rtn_ready_o=0.
  - The first cycle after deassertion: rtn_ready_o=1, pipe_ready_o=1.
- **Latency:**
  - Pipeline to write port is combinational: 0 cycles.
  - Return to write port is at least 1 cycle: enqueue at edge N, w_v_o for that return is possible in cycle N+1.
- **Simultaneous enqueue and dequeue:** count unchanged.
- **Full FIFO with rtn_v_i=1:** rtn_ready_o=0 and no enqueue. force_drain frees a slot, and rtn_ready_o rises the next cycle.
- **Starvation bound.** Once the FIFO becomes non-empty, its head writes within starve_limit_p+1 cycles, even under continuous real pipeline writes.
- **Reset mid-operation:** buffered returns are discarded, with no write issued.
- **Wrap-around:** pointers wrap modulo fifo_els_p. Full and empty are distinguished by the count.

## Test plan
- **Basic arbitration.** Reset, then pipe_v_i=1 addr 5 data 0xA5A5A5A5 while rtn_v_i=1 addr 7 data 0x11 in the same cycle.
  - Cycle 0: w writes r5=0xA5A5A5A5; the return is enqueued and fifo_count_o=1.
  - Cycle 1 (pipe idle): w writes r7=0x11 and fifo_count_o=0.
- **Starvation.** Pipe continuously writes r1..; one return to r9 is enqueued at cycle 0.
  - With starve_limit_p=8, pipe_ready_o=0 for exactly one cycle at cycle 8.
  - w writes r9 in that cycle, and the pipeline write completes the next cycle with its inputs held.
- **Full FIFO.** Pipe continuously busy and 5 back-to-back returns with fifo_els_p=4.
  - rtn_ready_o drops after 4 accepts.
  - force_drain fires the next cycle, and the 5th return is accepted one cycle later.
- **x0 handling.**
  - A return to r0 is accepted with fifo_count_o unchanged and no write.
  - A pipe write to r0 gives pipe_ready_o=1 and w_v_o=0. With a buffered return present, that return drains in the same cycle.
- **Reset mid-operation.** With 3 buffered returns, assert reset_i asynchronously mid-cycle.
  - w_v_o=0 immediately and fifo_count_o=0.
  - After deassertion, no stale write ever appears.
- **Pointer wrap.** Stream 12 returns with an idle pipe.
  - All 12 are written in order with data matching addresses r1..r12.
  - fifo_count_o never exceeds 1.
